// File: rtl/data_bus_bridge.sv
// Multi-cycle bridge from the MEM stage's single-cycle RAM request to a valid/ready data bus.
// Stalls the pipeline until the access completes and holds load data for MEM/WB.
module data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  input  logic        stall_other,
  output logic        stall_req,
  output logic [31:0] ram_read_data,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request transfers on a rising edge where bus_req_valid and
  // bus_req_ready are both 1; valid and fields stay stable until that edge.
  // bus_resp_valid is only honoured while waiting for the single outstanding access.

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ram_en) begin
          state_d = S_REQ;
          addr_d  = ram_addr;
          strb_d  = ram_write_en;
          wdata_d = ram_write_data;
          write_d = (ram_write_en != 4'b0000);
        end
      end
      S_REQ: begin
        if (bus_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (bus_resp_valid) begin
          if (!write_q) rdata_d = bus_rdata;
          state_d = S_DONE;
        end else if (cnt_q >= TO_LAST) begin
          // Abandoned access returns zero so WB never sees stale data.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (!stall_other) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_req     = ((state_q == S_IDLE) && ram_en) || (state_q == S_REQ) || (state_q == S_WAIT);
    bus_req_valid = (state_q == S_REQ);
    bus_addr      = bus_req_valid ? addr_q  : 32'h0;
    bus_write     = bus_req_valid ? write_q : 1'b0;
    bus_wstrb     = bus_req_valid ? strb_q  : 4'h0;
    bus_wdata     = bus_req_valid ? wdata_q : 32'h0;
    bus_err       = (state_q == S_DONE) && err_q;
    ram_read_data = rdata_q;
    dbg_state_o   = state_q;
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge: load, store, back-to-back, external stall,
// timeout (TIMEOUT_CYCLES=4) and reset in the middle of a wait.
module tb_data_bus_bridge;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en = 1'b0;
  logic [3:0]  ram_write_en = 4'h0;
  logic [31:0] ram_addr = 32'h0;
  logic [31:0] ram_write_data = 32'h0;
  logic        stall_other = 1'b0;
  logic        stall_req;
  logic [31:0] ram_read_data;
  logic        bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int fails  = 0;
  int hs_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hs_addr_q[$];

  data_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .stall_other(stall_other),
    .stall_req(stall_req), .ram_read_data(ram_read_data), .bus_err(bus_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_write(bus_write), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus_req_valid && bus_req_ready) begin
      hs_cnt <= hs_cnt + 1;
      hs_addr_q.push_back(bus_addr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: new cycle starts 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    #1;
    checks++; if (dbg_state_o !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", dbg_state_o, ST_IDLE); end
    checks++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    checks++; if (ram_read_data !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", ram_read_data); end
    checks++; if (bus_req_valid !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL reset_valid_err: got %b%b expected 00", bus_req_valid, bus_err); end
    checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin fails++; $display("FAIL reset_bus_fields: got %h/%h expected 0/0", bus_addr, bus_wdata); end
    ram_en = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b1) begin fails++; $display("FAIL reset_stall_comb: got %b expected 1", stall_req); end
    ram_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    step();
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h100; bus_req_ready = 1'b1;
    #1;
    checks++; if (dbg_state_o !== ST_IDLE || bus_req_valid !== 1'b0) begin fails++; $display("FAIL load_c0: got st=%0d v=%b expected st=0 v=0", dbg_state_o, bus_req_valid); end
    if (stall_req === 1'b1) stalls++;
    step(); #1;
    checks++; if (dbg_state_o !== ST_REQ || bus_req_valid !== 1'b1) begin fails++; $display("FAIL load_req: got st=%0d v=%b expected st=1 v=1", dbg_state_o, bus_req_valid); end
    checks++; if (bus_addr !== 32'h100 || bus_write !== 1'b0 || bus_wstrb !== 4'h0) begin fails++; $display("FAIL load_req_fields: got %h w=%b s=%h expected 100 w=0 s=0", bus_addr, bus_write, bus_wstrb); end
    if (stall_req === 1'b1) stalls++;
    step();
    bus_resp_valid = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (dbg_state_o !== ST_WAIT || bus_addr !== 32'h0) begin fails++; $display("FAIL load_wait: got st=%0d addr=%h expected st=2 addr=0", dbg_state_o, bus_addr); end
    if (stall_req === 1'b1) stalls++;
    step();
    bus_resp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++; if (dbg_state_o !== ST_DONE || stall_req !== 1'b0) begin fails++; $display("FAIL load_done: got st=%0d stall=%b expected st=3 stall=0", dbg_state_o, stall_req); end
    checks++; if (ram_read_data !== 32'hCAFEF00D) begin fails++; $display("FAIL load_rdata: got %h expected cafef00d", ram_read_data); end
    checks++; if (stalls != 3) begin fails++; $display("FAIL load_stall_cycles: got %0d expected 3", stalls); end
    step();
    ram_en = 1'b0; bus_req_ready = 1'b0;
    #1;
    checks++; if (dbg_state_o !== ST_IDLE || stall_req !== 1'b0) begin fails++; $display("FAIL load_idle: got st=%0d stall=%b expected st=0 stall=0", dbg_state_o, stall_req); end
  endtask

  task automatic test_store();
    int vcyc;
    vcyc = 0;
    step();
    ram_en = 1'b1; ram_write_en = 4'b0100; ram_write_data = 32'h00AB0000; ram_addr = 32'h204; bus_req_ready = 1'b0;
    #1;
    checks++; if (stall_req !== 1'b1) begin fails++; $display("FAIL store_c0_stall: got %b expected 1", stall_req); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 4) bus_req_ready = 1'b1;
      #1;
      if (bus_req_valid === 1'b1) vcyc++;
      checks++;
      if (dbg_state_o !== ST_REQ || bus_wstrb !== 4'b0100 || bus_wdata !== 32'h00AB0000 || bus_write !== 1'b1 || bus_addr !== 32'h204) begin
        fails++; $display("FAIL store_req_stable[%0d]: got st=%0d s=%h d=%h w=%b a=%h expected st=1 s=4 d=00ab0000 w=1 a=204", i, dbg_state_o, bus_wstrb, bus_wdata, bus_write, bus_addr);
      end
    end
    checks++; if (vcyc != 5) begin fails++; $display("FAIL store_valid_cycles: got %0d expected 5", vcyc); end
    step();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (dbg_state_o !== ST_WAIT) begin fails++; $display("FAIL store_wait: got %0d expected 2", dbg_state_o); end
    step();
    bus_resp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++; if (dbg_state_o !== ST_DONE || ram_read_data !== 32'hCAFEF00D) begin fails++; $display("FAIL store_done_rdata: got st=%0d rd=%h expected st=3 rd=cafef00d", dbg_state_o, ram_read_data); end
    step();
    ram_en = 1'b0; ram_write_en = 4'h0; ram_write_data = 32'h0;
    #1;
    checks++; if (dbg_state_o !== ST_IDLE) begin fails++; $display("FAIL store_idle: got %0d expected 0", dbg_state_o); end
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_cnt;
    exp_q.delete();
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    step();
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h300; bus_req_ready = 1'b1;
    step(); #1;
    checks++; if (dbg_state_o !== ST_REQ || bus_addr !== 32'h300) begin fails++; $display("FAIL b2b_req1: got st=%0d a=%h expected st=1 a=300", dbg_state_o, bus_addr); end
    step();
    bus_resp_valid = 1'b1; bus_rdata = 32'h12345678;
    step();
    bus_resp_valid = 1'b0;
    #1;
    checks++; if (dbg_state_o !== ST_DONE || ram_read_data !== 32'h12345678) begin fails++; $display("FAIL b2b_done1: got st=%0d rd=%h expected st=3 rd=12345678", dbg_state_o, ram_read_data); end
    step();
    ram_write_en = 4'hF; ram_addr = 32'h304; ram_write_data = 32'h89ABCDEF;
    #1;
    checks++; if (dbg_state_o !== ST_IDLE || stall_req !== 1'b1) begin fails++; $display("FAIL b2b_idle_gap: got st=%0d stall=%b expected st=0 stall=1", dbg_state_o, stall_req); end
    step(); #1;
    checks++; if (dbg_state_o !== ST_REQ || bus_addr !== 32'h304 || bus_write !== 1'b1 || bus_wdata !== 32'h89ABCDEF) begin fails++; $display("FAIL b2b_req2: got st=%0d a=%h w=%b d=%h expected st=1 a=304 w=1 d=89abcdef", dbg_state_o, bus_addr, bus_write, bus_wdata); end
    step();
    bus_resp_valid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    step();
    bus_resp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++; if (dbg_state_o !== ST_DONE || ram_read_data !== 32'h12345678) begin fails++; $display("FAIL b2b_done2: got st=%0d rd=%h expected st=3 rd=12345678", dbg_state_o, ram_read_data); end
    step();
    ram_en = 1'b0; ram_write_en = 4'h0; ram_write_data = 32'h0; bus_req_ready = 1'b0;
    #1;
    checks++; if (hs_cnt - hs0 != 2) begin fails++; $display("FAIL b2b_handshakes: got %0d expected 2", hs_cnt - hs0); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (hs_addr_q.size() <= hs0 + i) begin fails++; $display("FAIL b2b_addr[%0d]: got none expected %h", i, exp_q[i]); end
      else if (hs_addr_q[hs0 + i] !== exp_q[i]) begin fails++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, hs_addr_q[hs0 + i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_other();
    int hs0;
    hs0 = hs_cnt;
    step();
    ram_en = 1'b1; ram_addr = 32'h310; bus_req_ready = 1'b1;
    step();
    step();
    bus_resp_valid = 1'b1; bus_rdata = 32'h0BADBEEF;
    step();
    bus_resp_valid = 1'b0; bus_rdata = 32'h0; bus_req_ready = 1'b0; stall_other = 1'b1;
    #1;
    checks++; if (dbg_state_o !== ST_DONE || ram_read_data !== 32'h0BADBEEF) begin fails++; $display("FAIL so_done: got st=%0d rd=%h expected st=3 rd=0badbeef", dbg_state_o, ram_read_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) stall_other = 1'b0;
      #1;
      checks++;
      if (dbg_state_o !== ST_DONE || stall_req !== 1'b0 || bus_req_valid !== 1'b0) begin
        fails++; $display("FAIL so_hold[%0d]: got st=%0d stall=%b v=%b expected st=3 stall=0 v=0", i, dbg_state_o, stall_req, bus_req_valid);
      end
    end
    step();
    ram_en = 1'b0;
    #1;
    checks++; if (dbg_state_o !== ST_IDLE) begin fails++; $display("FAIL so_idle: got %0d expected 0", dbg_state_o); end
    checks++; if (hs_cnt - hs0 != 1) begin fails++; $display("FAIL so_handshakes: got %0d expected 1", hs_cnt - hs0); end
  endtask

  task automatic test_timeout();
    step();
    ram_en = 1'b1; ram_addr = 32'h400; bus_req_ready = 1'b1;
    step(); #1;
    checks++; if (dbg_state_o !== ST_REQ) begin fails++; $display("FAIL to_req: got %0d expected 1", dbg_state_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      bus_req_ready = 1'b0;
      #1;
      checks++;
      if (dbg_state_o !== ST_WAIT || bus_err !== 1'b0 || stall_req !== 1'b1) begin
        fails++; $display("FAIL to_wait[%0d]: got st=%0d err=%b stall=%b expected st=2 err=0 stall=1", i, dbg_state_o, bus_err, stall_req);
      end
    end
    step(); #1;
    checks++; if (dbg_state_o !== ST_DONE || bus_err !== 1'b1 || stall_req !== 1'b0) begin fails++; $display("FAIL to_done: got st=%0d err=%b stall=%b expected st=3 err=1 stall=0", dbg_state_o, bus_err, stall_req); end
    checks++; if (ram_read_data !== 32'h0) begin fails++; $display("FAIL to_rdata: got %h expected 0", ram_read_data); end
    step();
    ram_en = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h55555555;
    #1;
    checks++; if (dbg_state_o !== ST_IDLE || bus_err !== 1'b0) begin fails++; $display("FAIL to_err_pulse: got st=%0d err=%b expected st=0 err=0", dbg_state_o, bus_err); end
    step();
    bus_resp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++; if (ram_read_data !== 32'h0 || dbg_state_o !== ST_IDLE) begin fails++; $display("FAIL to_stray_resp: got rd=%h st=%0d expected rd=0 st=0", ram_read_data, dbg_state_o); end
  endtask

  task automatic test_reset_mid_wait();
    step();
    ram_en = 1'b1; ram_addr = 32'h500; bus_req_ready = 1'b1;
    step();
    step();
    bus_resp_valid = 1'b1; bus_rdata = 32'hA5A5A5A5;
    step();
    bus_resp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++; if (ram_read_data !== 32'hA5A5A5A5) begin fails++; $display("FAIL rst_pre_rdata: got %h expected a5a5a5a5", ram_read_data); end
    step();
    ram_addr = 32'h504;
    step();
    step();
    bus_req_ready = 1'b0;
    #1;
    checks++; if (dbg_state_o !== ST_WAIT) begin fails++; $display("FAIL rst_in_wait: got %0d expected 2", dbg_state_o); end
    step();
    rst = 1'b1; ram_en = 1'b0;
    step();
    rst = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h77777777;
    #1;
    checks++; if (dbg_state_o !== ST_IDLE || stall_req !== 1'b0 || bus_req_valid !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL rst_idle: got st=%0d stall=%b v=%b err=%b expected 0 0 0 0", dbg_state_o, stall_req, bus_req_valid, bus_err); end
    checks++; if (ram_read_data !== 32'h0 || bus_addr !== 32'h0) begin fails++; $display("FAIL rst_outputs: got rd=%h a=%h expected 0/0", ram_read_data, bus_addr); end
    step();
    bus_resp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    checks++; if (ram_read_data !== 32'h0 || dbg_state_o !== ST_IDLE) begin fails++; $display("FAIL rst_stale_resp: got rd=%h st=%0d expected rd=0 st=0", ram_read_data, dbg_state_o); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_stall_other();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Multi-cycle bridge between the MEM stage's single-cycle RAM request and an external valid/ready data bus. It sits directly downstream of MEM and consumes `ram_en`, `ram_write_en`, `ram_addr` and `ram_write_data`. It raises a stall request to pipeline control until the bus access completes. Returned load data is held in a register for the MEM/WB path.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before the access is abandoned with an error.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ram_en`  in  1  access request from MEM; held stable by the pipeline while `stall_req`=1.
- `ram_write_en`  in  4  byte write strobes; 0 means read.
- `ram_addr`  in  32  word-aligned address.
- `ram_write_data`  in  32  byte-lane-aligned store data.
- `stall_other`  in  1  a stall from another pipeline source is active.
- `stall_req`  out  1  freeze IF..MEM.
- `ram_read_data`  out  32  registered load data.
- `bus_err`  out  1  one-cycle pulse in DONE when the access timed out.
- `bus_req_valid`  out  1  request valid.
- `bus_req_ready`  in  1  bus accepts the request.
- `bus_addr`  out  32  request address.
- `bus_write`  out  1  1 = write.
- `bus_wstrb`  out  4  write byte strobes.
- `bus_wdata`  out  32  write data.
- `bus_resp_valid`  in  1  read data ready or write acknowledge.
- `bus_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE to REQ when `ram_en`=1. On this transition, latch `addr_q`=`ram_addr`, `strb_q`=`ram_write_en`, `wdata_q`=`ram_write_data`, and `write_q`=(`ram_write_en`!=0).
  - REQ: `bus_req_valid`=1 with the latched fields. Stay while `bus_req_ready`=0. When `bus_req_ready`=1, go to WAIT and clear the timeout counter.
  - WAIT: on `bus_resp_valid`=1, latch `ram_read_data`=`bus_rdata` (reads only; writes leave it unchanged) and go to DONE.
  - WAIT timeout: otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1 without a response, set `err_q`=1, set `ram_read_data`=0, and go to DONE.
  - DONE: `stall_req`=0, so the pipeline advances. Stay in DONE while `stall_other`=1. Go to IDLE when `stall_other`=0. Clear `err_q` on leaving DONE.
- `stall_req` = (IDLE & `ram_en`) | REQ | WAIT. It is combinational and asserts in the same cycle the request appears.
- Bus outputs (`bus_addr`, `bus_write`, `bus_wstrb`, `bus_wdata`) are 0 in every state except REQ.
- `bus_err` = DONE & `err_q`.
- A MEM request with `ram_en`=1 and `ram_write_en`=0 (including a misaligned store that MEM has squashed) is issued as a read. This is harmless; WB ignores the data.
- `bus_resp_valid` is ignored outside WAIT, including stale responses after a timeout or reset.
- Timeout counter: 16 bits, saturating. `TIMEOUT_CYCLES` must be in the range 2..65535.

## Timing
- Reset: state=IDLE, `ram_read_data`=0, `err_q`=0, counter=0. All outputs are 0 (`stall_req`=0 unless `ram_en`=1 in that cycle).
- A reset during REQ, WAIT or DONE abandons the access. The bridge is in IDLE the cycle after.
- Minimum access latency (ready immediate, response one cycle later):
  - cycle 0 IDLE (stall=1), cycle 1 REQ, cycle 2 WAIT, cycle 3 DONE (stall=0).
  - The pipeline advances at the end of cycle 3, and the next request can be seen in cycle 4.
- `ram_read_data` is valid from the DONE cycle. It holds until the next read response, which is at least 3 cycles later.
- `bus_req_valid`, once raised, stays high with stable fields until `bus_req_ready`=1.
- At most one outstanding transaction.

## Test plan
- Load word: `ram_en`=1, `ram_write_en`=0, `ram_addr`=0x100; ready immediate, `bus_rdata`=0xCAFEF00D one cycle after acceptance.
  - Expect `stall_req`=1 for 3 cycles, `bus_write`=0, `bus_addr`=0x100.
  - Expect `ram_read_data`=0xCAFEF00D in DONE.
- Store byte: `ram_write_en`=4'b0100, `ram_write_data`=0x00AB0000, addr 0x204; ready held low 4 cycles.
  - Expect `bus_req_valid` high for 5 cycles with `bus_wstrb`=0100 and `bus_wdata`=0x00AB0000 stable throughout.
  - Expect `ram_read_data` unchanged.
- Back-to-back: load then store with no gap.
  - Expect two distinct bus requests.
  - Expect no duplicate issue of the load.
  - Expect IDLE between DONE and the second REQ.
- `stall_other`=1 for 3 cycles during DONE.
  - Expect the FSM to stay in DONE with `stall_req`=0.
  - Expect no new request; IDLE after `stall_other` drops.
- Timeout with `TIMEOUT_CYCLES`=4: request accepted, no response.
  - Expect DONE 4 cycles after entering WAIT, with `bus_err`=1 for exactly one cycle and `ram_read_data`=0.
  - A later stray `bus_resp_valid` is ignored.
- Reset asserted mid-WAIT.
  - Expect IDLE next cycle with all outputs 0.
  - A subsequent `bus_resp_valid` does not change `ram_read_data`.
